// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg -- shared constants for the flit buffer.
//   FB_FLIT_W        : default flit width in bits
//   FB_NODES_PER_ROW : mesh nodes per row
//   FB_NODES_PER_COL : mesh nodes per column
//   FB_DESTID_W      : destination-ID width, wide enough to name every node
//   FB_DEST_LSB/MSB  : bit range of the destination field inside a flit
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_FLIT_W        = 32;
  localparam int FB_NODES_PER_ROW = 4;
  localparam int FB_NODES_PER_COL = 4;
  localparam int FB_DESTID_W      = $clog2(FB_NODES_PER_ROW * FB_NODES_PER_COL);
  localparam int FB_DEST_LSB      = 0;
  localparam int FB_DEST_MSB      = FB_DEST_LSB + FB_DESTID_W - 1;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo -- storage and pointers for the input buffer.
//   clk, rst : clock, synchronous active-high reset
//   push_i   : write wdata_i at wr_ptr (caller guarantees not full)
//   pop_i    : advance rd_ptr (caller guarantees not empty)
//   wdata_i  : write data
//   rdata_o  : entry at rd_ptr, read combinationally from the flops
//   count_o  : occupancy
//   full_o, empty_o : occupancy flags
// Reset clears pointers and count only; storage is left as-is. Reset wins
// over any push/pop in the same cycle.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // DEPTH is a power of two, so pointer wrap is the natural AW-bit overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/input_buffer.sv
// ---------------------------------------------------------------------------
// input_buffer -- router input-port flit FIFO feeding route compute.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid_i   : upstream flit valid
//   in_flit_i    : upstream flit
//   in_ready_o   : buffer can accept a flit this cycle
//   head_valid_o : head flit present (route-compute valid)
//   head_flit_o  : head flit
//   dest_node_o  : destination field of the head flit
//   grant_i      : switch-allocator grant, pops the head
//   count_o      : current occupancy
//   credit_o     : one-cycle pulse the cycle after each pop
//                  (only when FB_CREDIT_EN is defined)
//
// Handshake: a push happens on a rising edge where in_valid_i and in_ready_o
// are both 1; a pop happens where grant_i and head_valid_o are both 1. A
// grant with no head is ignored. in_ready_o depends on occupancy only (no
// same-cycle pass-through when full) and is forced low during reset.
// ---------------------------------------------------------------------------
module input_buffer
  import fb_pkg::*;
#(
  parameter int FLIT_W   = FB_FLIT_W,
  parameter int DEPTH    = 4,
  parameter int DESTID_W = FB_DESTID_W,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  input  logic [FLIT_W-1:0]   in_flit_i,
  output logic                in_ready_o,
  output logic                head_valid_o,
  output logic [FLIT_W-1:0]   head_flit_o,
  output logic [DESTID_W-1:0] dest_node_o,
  input  logic                grant_i,
`ifdef FB_CREDIT_EN
  output logic                credit_o,
`endif
  output logic [CW-1:0]       count_o
);

  logic push;
  logic pop;
  logic full;
  logic empty;

  assign in_ready_o   = !rst && !full;
  assign head_valid_o = !empty;
  assign push         = in_valid_i && in_ready_o;
  assign pop          = grant_i && head_valid_o;

  sync_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_flit_i),
    .rdata_o (head_flit_o),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  assign dest_node_o = head_flit_o[FB_DEST_LSB +: DESTID_W];

`ifdef FB_CREDIT_EN
  logic credit_q, credit_d;

  // A pop during reset is discarded, so it must not return a credit.
  always_comb begin
    credit_d = pop && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) credit_q <= 1'b0;
    else     credit_q <= credit_d;
  end

  assign credit_o = credit_q;
`endif

endmodule

// File: tb/tb_input_buffer.sv
module tb_input_buffer;
  localparam int FLIT_W   = 32;
  localparam int DEPTH    = 4;
  localparam int DESTID_W = 4;
  localparam int CW       = $clog2(DEPTH + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                in_valid_i = 1'b0;
  logic [FLIT_W-1:0]   in_flit_i  = '0;
  logic                grant_i    = 1'b0;
  logic                in_ready_o;
  logic                head_valid_o;
  logic [FLIT_W-1:0]   head_flit_o;
  logic [DESTID_W-1:0] dest_node_o;
  logic [CW-1:0]       count_o;
`ifdef FB_CREDIT_EN
  logic                credit_o;
`endif

  input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .DESTID_W(DESTID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_flit_i    (in_flit_i),
    .in_ready_o   (in_ready_o),
    .head_valid_o (head_valid_o),
    .head_flit_o  (head_flit_o),
    .dest_node_o  (dest_node_o),
    .grant_i      (grant_i),
`ifdef FB_CREDIT_EN
    .credit_o     (credit_o),
`endif
    .count_o      (count_o)
  );

  // scoreboard
  logic [FLIT_W-1:0] exp_q[$];
  int  m_cnt    = 0;
  logic m_credit = 1'b0;
  int  n_checks = 0;
  int  n_fail   = 0;

  // One clock cycle: apply inputs at negedge, compare outputs against the
  // model state, then update the model for what the edge will do.
  task automatic cycle(input logic v, input logic [FLIT_W-1:0] f, input logic g,
                       input string tag);
    logic do_push, do_pop;
    logic [FLIT_W-1:0] h;
    @(negedge clk);
    in_valid_i = v; in_flit_i = f; grant_i = g;
    #1;
    n_checks++;
    if (count_o !== CW'(m_cnt)) begin
      n_fail++; $display("FAIL %s count: got %0d expected %0d", tag, count_o, m_cnt);
    end
    n_checks++;
    if (in_ready_o !== (m_cnt != DEPTH)) begin
      n_fail++; $display("FAIL %s in_ready: got %b expected %b", tag, in_ready_o, m_cnt != DEPTH);
    end
    n_checks++;
    if (head_valid_o !== (m_cnt != 0)) begin
      n_fail++; $display("FAIL %s head_valid: got %b expected %b", tag, head_valid_o, m_cnt != 0);
    end
    if (m_cnt != 0) begin
      h = exp_q[0];
      n_checks++;
      if (head_flit_o !== h) begin
        n_fail++; $display("FAIL %s head_flit: got %h expected %h", tag, head_flit_o, h);
      end
      n_checks++;
      if (dest_node_o !== h[DESTID_W-1:0]) begin
        n_fail++; $display("FAIL %s dest_node: got %h expected %h", tag, dest_node_o, h[DESTID_W-1:0]);
      end
    end
`ifdef FB_CREDIT_EN
    n_checks++;
    if (credit_o !== m_credit) begin
      n_fail++; $display("FAIL %s credit: got %b expected %b", tag, credit_o, m_credit);
    end
`endif
    do_push = v && (m_cnt != DEPTH);
    do_pop  = g && (m_cnt != 0);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(f);
    m_cnt    = m_cnt + int'(do_push) - int'(do_pop);
    m_credit = do_pop;
    @(posedge clk);
  endtask

  // Reset for one edge with push and grant both asserted: both must be ignored.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; in_valid_i = 1'b1; grant_i = 1'b1; in_flit_i = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL %s in_ready_in_reset: got %b expected 0", tag, in_ready_o);
    end
    @(posedge clk);
    exp_q.delete();
    m_cnt = 0; m_credit = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid_i = 1'b0; grant_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset("reset");
    cycle(1'b0, '0, 1'b1, "reset_idle");
  endtask

  task automatic test_first_push();
    cycle(1'b1, 32'h0000_0005, 1'b0, "first_push");
    cycle(1'b0, '0, 1'b0, "first_head");
    n_checks++;
    if (dest_node_o !== 4'd5 || count_o !== CW'(1) || head_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL first_head_const: dest=%0d cnt=%0d hv=%b expected 5 1 1",
                         dest_node_o, count_o, head_valid_o);
    end
    cycle(1'b0, '0, 1'b1, "first_pop");
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'hA000_0000 + i, 1'b0, "fill");
    cycle(1'b1, 32'hBAD0_0005, 1'b0, "fifth_push");
    cycle(1'b0, '0, 1'b0, "full_hold");
    n_checks++;
    if (count_o !== CW'(4) || in_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL full_const: cnt=%0d rdy=%b expected 4 0", count_o, in_ready_o);
    end
    // pop only, no pass-through
    cycle(1'b1, 32'hBAD0_0006, 1'b1, "full_pop_push");
    cycle(1'b0, '0, 1'b0, "after_full_pop");
    n_checks++;
    if (count_o !== CW'(3) || in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL after_full_pop_const: cnt=%0d rdy=%b expected 3 1", count_o, in_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    // drain to 2
    cycle(1'b0, '0, 1'b1, "drain");
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'hC000_0010 + i, 1'b1, "b2b");
    cycle(1'b0, '0, 1'b0, "b2b_hold");
    n_checks++;
    if (count_o !== CW'(2)) begin
      n_fail++; $display("FAIL b2b_count_const: got %0d expected 2", count_o);
    end
  endtask

  task automatic test_credit_burst();
    // three consecutive pops from a count of 3
    cycle(1'b1, 32'hD000_0001, 1'b0, "credit_fill");
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, "credit_pop");
    cycle(1'b0, '0, 1'b0, "credit_tail");
    cycle(1'b0, '0, 1'b0, "credit_idle");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hE000_0000 + i, 1'b0, "pre_reset");
    apply_reset("mid_reset");
    cycle(1'b0, '0, 1'b1, "post_reset_grant");
    cycle(1'b0, '0, 1'b0, "post_reset_idle");
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_full();
    test_back_to_back();
    test_credit_burst();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
